// File: rtl/serial_loader_pkg.sv
// Shared state encodings and sizing helper for the serial_loader block.
package serial_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Wide enough to hold WIDTH+1 (data bits plus optional parity) without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit counter for serial_loader: synchronous clear, count enable, terminal-count flag.
module ser_bit_counter
    import serial_loader_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NBITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        en_i,
    output logic [cnt_width(WIDTH)-1:0] cnt_o,
    output logic                        tc_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flags the cycle in which the final bit of the word is being emitted.
    assign tc_o  = (cnt_q == CNT_W'(NBITS - 1));
    assign cnt_o = cnt_q;

endmodule

// File: rtl/serial_loader.sv
// Parallel-to-serial loader driving a downstream shift register (D/en pair).
// Define SERIAL_LOADER_PARITY_EN to append an even-parity bit after the data bits.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             stall,
    output logic             load_ready,
    output logic             ser_d,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
`ifdef SERIAL_LOADER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] hold_q;
    logic             load_ready_q;
    logic             ser_d_q;
    logic             ser_en_q;
    logic             busy_q;
    logic             done_q;
    logic             ser_d_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt;

    assign cnt_clr = (state_q == IDLE) && load_valid;
    assign cnt_en  = (state_q == SHIFT) && !stall;

    ser_bit_counter #(
        .WIDTH (WIDTH),
        .NBITS (NBITS)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        ser_d_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CNT_W'(i)) begin
                ser_d_d = (MSB_FIRST != 0) ? hold_q[WIDTH-1-i] : hold_q[i];
            end
        end
`ifdef SERIAL_LOADER_PARITY_EN
        if (cnt == CNT_W'(WIDTH)) begin
            ser_d_d = ^hold_q;
        end
`endif
    end

    // busy/load_ready track the state being entered; ser_en/done lag the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            load_ready_q <= 1'b1;
            ser_d_q      <= 1'b0;
            ser_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            ser_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        hold_q       <= load_data;
                        state_q      <= SHIFT;
                        load_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!stall) begin
                        ser_en_q <= 1'b1;
                        ser_d_q  <= ser_d_d;
                        if (cnt_tc) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign ser_d      = ser_d_q;
    assign ser_en     = ser_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: MSB- and LSB-first instances share one stimulus stream.
module tb_serial_loader;

`ifdef SERIAL_LOADER_PARITY_EN
    localparam int NB = 5;
    localparam logic [4:0] M_1011 = 5'b10111, L_1011 = 5'b11011;
    localparam logic [4:0] M_1000 = 5'b10001, L_1000 = 5'b00011;
    localparam logic [4:0] M_A    = 5'b10100, L_A    = 5'b01010;
    localparam logic [4:0] M_5    = 5'b01010, L_5    = 5'b10100;
    localparam logic [4:0] M_0111 = 5'b01111, L_0111 = 5'b11101;
`else
    localparam int NB = 4;
    localparam logic [3:0] M_1011 = 4'b1011, L_1011 = 4'b1101;
    localparam logic [3:0] M_1000 = 4'b1000, L_1000 = 4'b0001;
    localparam logic [3:0] M_A    = 4'b1010, L_A    = 4'b0101;
    localparam logic [3:0] M_5    = 4'b0101, L_5    = 4'b1010;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [3:0] load_data;
    logic       stall;
    logic       load_ready, ser_d, ser_en, busy, done;
    logic       load_ready_l, ser_d_l, ser_en_l, busy_l, done_l;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc[$];

    always #5 clk = ~clk;

    serial_loader #(.WIDTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .stall(stall),
        .load_ready(load_ready), .ser_d(ser_d), .ser_en(ser_en), .busy(busy), .done(done)
    );

    serial_loader #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .stall(stall),
        .load_ready(load_ready_l), .ser_d(ser_d_l), .ser_en(ser_en_l), .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; record edges on which a word is accepted; settle 1 time unit past the edge.
    task automatic tick();
        logic a;
        a = load_valid && load_ready;
        @(posedge clk);
        cyc++;
        if (a) acc_cyc.push_back(cyc);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic en,
                            input logic bsy, input logic dn);
        chk({tag, "_ready"}, load_ready, rdy);
        chk({tag, "_en"},    ser_en,     en);
        chk({tag, "_busy"},  busy,       bsy);
        chk({tag, "_done"},  done,       dn);
    endtask

    task automatic chk_reset(input string tag);
        chk_outs(tag, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, "_d"},    ser_d,   1'b0);
        chk({tag, "_d_l"},  ser_d_l, 1'b0);
        chk({tag, "_en_l"}, ser_en_l, 1'b0);
    endtask

    // Expect bits [from..to] of a word on consecutive ser_en cycles; seq MSB is the first bit sent.
    task automatic run_bits(input string tag, input logic [NB-1:0] seq_m,
                            input logic [NB-1:0] seq_l, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            tick();
            chk_outs($sformatf("%s_b%0d", tag, i), 1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("%s_d%0d", tag, i),   ser_d,   seq_m[NB-1-i]);
            chk($sformatf("%s_dl%0d", tag, i),  ser_d_l, seq_l[NB-1-i]);
        end
    endtask

    task automatic accept(input string tag, input logic [3:0] word);
        load_valid = 1'b1;
        load_data  = word;
        tick();
        chk_outs({tag, "_acc"}, 1'b0, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        load_data  = ~word;
    endtask

    task automatic finish_word(input string tag);
        tick();
        chk_outs({tag, "_donecyc"}, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs({tag, "_after"}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 4'h0;
        stall      = 1'b0;
        #1;
        chk_reset("rst0");
        tick();
        tick();
        rst = 1'b0;

        // Basic MSB-first word, busy for the idle-output cycle plus each bit.
        accept("t1", 4'b1011);
        run_bits("t1", M_1011, L_1011, 0, NB-1);
        finish_word("t1");

        // LSB-first ordering is checked on the second instance.
        accept("t2", 4'b1000);
        run_bits("t2", M_1000, L_1000, 0, NB-1);
        finish_word("t2");

        // Stall for three edges after the second bit.
        accept("t3", 4'b1011);
        run_bits("t3", M_1011, L_1011, 0, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs($sformatf("t3_st%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("t3_hold%0d", i),  ser_d,   M_1011[NB-2]);
            chk($sformatf("t3_holdl%0d", i), ser_d_l, L_1011[NB-2]);
        end
        stall = 1'b0;
        run_bits("t3", M_1011, L_1011, 2, NB-1);
        finish_word("t3");

        // Reset after the third bit: immediate return to reset values, word discarded.
        accept("t4", 4'b1011);
        run_bits("t4", M_1011, L_1011, 0, 2);
        rst = 1'b1;
        #1;
        chk_reset("t4_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_reset($sformatf("t4_idle%0d", i));
        end

        // Back-to-back words with load_valid held high, starting on the first edge after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_cyc.delete();
        load_valid = 1'b1;
        load_data  = 4'hA;
        tick();
        chk_outs("t5_acc0", 1'b0, 1'b0, 1'b1, 1'b0);
        load_data = 4'h5;
        run_bits("t5a", M_A, L_A, 0, NB-1);
        tick();
        chk_outs("t5_done0", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("t5_acc1", 1'b0, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        load_data  = 4'hF;
        chk_int("t5_naccept", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) chk_int("t5_spacing", acc_cyc[1] - acc_cyc[0], NB + 2);
        run_bits("t5b", M_5, L_5, 0, NB-1);
        finish_word("t5b");

`ifdef SERIAL_LOADER_PARITY_EN
        // Even parity appended after the data bits.
        accept("t6", 4'b0111);
        run_bits("t6", M_0111, L_0111, 0, NB-1);
        finish_word("t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
